// File: rtl/unit_lit_mark_seq.sv
// Sequential unit-literal marker: snapshots unit-clause slots, scans LANES per cycle, builds mark/polarity maps.
// Optional build macro ULM_EARLY_ABORT_EN: leave SCAN at the end of the cycle in which the first conflict appears.
module unit_lit_mark_seq #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned NUM_VARS    = 256,
  parameter int unsigned NUM_CLAUSES = 256,
  parameter int unsigned LANES       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CLAUSES*WIDTH-1:0]   unit_clauses_packed,
  input  logic [NUM_CLAUSES-1:0]         unit_clause_detected_packed,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_VARS-1:0]            mark_all_unit_clauses_packed,
  output logic [NUM_VARS-1:0]            bool_val_of_unit_lits_packed,
  output logic                           conflict,
  output logic [WIDTH-2:0]               conflict_var,
  output logic                           range_err
);

  localparam int unsigned SW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int unsigned VW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int unsigned PW = $clog2(NUM_CLAUSES + LANES) + 1;
  localparam int unsigned IW = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_LIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]      clauses_q [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] det_q;
  logic [NUM_VARS-1:0]   mark_q, mark_d;
  logic [NUM_VARS-1:0]   pol_q, pol_d;
  logic                  conflict_q, conflict_d;
  logic [IW-1:0]         cvar_q, cvar_d;
  logic                  rerr_q, rerr_d;
  logic                  busy_q, out_valid_q;

  // Per-lane scratch for the scan loop
  int unsigned           slot_n;
  logic [SW-1:0]         slot;
  logic [WIDTH-1:0]      sel;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         vi;
  logic                  pol;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mark_d     = mark_q;
    pol_d      = pol_q;
    conflict_d = conflict_q;
    cvar_d     = cvar_q;
    rerr_d     = rerr_q;
    slot_n     = 0;
    slot       = '0;
    sel        = '0;
    idx        = '0;
    vi         = '0;
    pol        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SCAN;
          ptr_d      = '0;
          mark_d     = '0;
          pol_d      = '0;
          conflict_d = 1'b0;
          cvar_d     = '0;
          rerr_d     = 1'b0;
        end
      end

      ST_SCAN: begin
        // Running mark/pol copies make lower lanes visible to higher lanes in the same cycle
        for (int unsigned l = 0; l < LANES; l++) begin
          slot_n = 32'(ptr_q) + l;
          if (slot_n < NUM_CLAUSES) begin
            slot = SW'(slot_n);
            if (det_q[slot]) begin
              sel = clauses_q[slot];
              idx = sel[WIDTH-1] ? IW'(-sel) : sel[WIDTH-2:0];
              pol = ~sel[WIDTH-1];
              if (sel != '0) begin
                if (sel == MIN_LIT || 32'(idx) >= NUM_VARS) begin
                  rerr_d = 1'b1;
                end else begin
                  vi = VW'(idx);
                  if (mark_d[vi]) begin
                    if (pol_d[vi] != pol) begin
                      if (!conflict_d) cvar_d = idx;
                      conflict_d = 1'b1;
                    end
                  end else begin
                    mark_d[vi] = 1'b1;
                    pol_d[vi]  = pol;
                  end
                end
              end
            end
          end
        end
        ptr_d = ptr_q + PW'(LANES);
        if (32'(ptr_q) + LANES >= NUM_CLAUSES) state_d = ST_DONE;
`ifdef ULM_EARLY_ABORT_EN
        if (conflict_d && !conflict_q) state_d = ST_DONE;
`else
`endif
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mark_q      <= '0;
      pol_q       <= '0;
      conflict_q  <= 1'b0;
      cvar_q      <= '0;
      rerr_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mark_q      <= mark_d;
      pol_q       <= pol_d;
      conflict_q  <= conflict_d;
      cvar_q      <= cvar_d;
      rerr_q      <= rerr_d;
      busy_q      <= (state_d != ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Input snapshot, taken only when a start is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLAUSES; i++) clauses_q[i] <= '0;
      det_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      for (int unsigned i = 0; i < NUM_CLAUSES; i++)
        clauses_q[i] <= unit_clauses_packed[i*WIDTH +: WIDTH];
      det_q <= unit_clause_detected_packed;
    end
  end

  assign busy                         = busy_q;
  assign out_valid                    = out_valid_q;
  assign mark_all_unit_clauses_packed = mark_q;
  assign bool_val_of_unit_lits_packed = pol_q;
  assign conflict                     = conflict_q;
  assign conflict_var                 = cvar_q;
  assign range_err                    = rerr_q;

endmodule
